// File: rtl/fetch_stage.sv
// Instruction fetch stage: requests one instruction at a time from imem, holds it
// for the datapath, then steps or redirects the PC; a misaligned target halts fetch.
module fetch_stage #(
  parameter int                    Data_Width = 32,
  parameter logic [Data_Width-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [Data_Width-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [Data_Width-1:0] imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [Data_Width-1:0] instr,
  output logic [Data_Width-1:0] pc,
  output logic [Data_Width-1:0] newPC,
  input  logic                  eq,
  input  logic                  Branch,
  input  logic                  JumpSel,
  input  logic [Data_Width-1:0] ImmOp,
  output logic                  halted
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    HALT
  } state_t;

  state_t                state;
  logic                  redirect;
  logic [Data_Width-1:0] next_pc;

  always_comb begin
    redirect = JumpSel | (Branch & eq);
    next_pc  = redirect ? (pc + ImmOp) : (pc + Data_Width'(4));
  end

  // The address is the PC itself, so it is stable for the whole request.
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      newPC       <= RESET_PC + Data_Width'(4);
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (next_pc[1:0] == 2'b00) begin
              pc       <= next_pc;
              newPC    <= next_pc + Data_Width'(4);
              imem_req <= 1'b1;
              state    <= FETCH;
            end else begin
              halted <= 1'b1;
              state  <= HALT;
            end
          end
        end
        HALT: begin
          imem_req <= 1'b0;
          state    <= HALT;
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter Data_Width, default 32, meaning the width of the instruction, PC and immediate.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0, meaning the PC loaded on reset.
REQ-003 Port clk  input  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port imem_req  output  1  SHALL indicate an instruction-memory read request.
REQ-006 Port imem_addr  output  Data_Width  SHALL carry the byte address of the requested instruction.
REQ-007 Port imem_ack  input  1  SHALL indicate that imem_rdata is valid this cycle.
REQ-008 Port imem_rdata  input  Data_Width  SHALL carry the returned instruction word.
REQ-009 Port instr_valid  output  1  SHALL indicate that instr, pc and newPC hold a fetched instruction.
REQ-010 Port instr_ready  input  1  SHALL indicate that the downstream decode/datapath consumes the instruction this cycle.
REQ-011 Port instr  output  Data_Width  SHALL carry the fetched instruction word.
REQ-012 Port pc  output  Data_Width  SHALL carry the address of instr.
REQ-013 Port newPC  output  Data_Width  SHALL carry pc+4, which the datapath uses as the link value for jumps.
REQ-014 Port eq  input  1  SHALL carry the datapath ALU equality flag for the instruction held in instr.
REQ-015 Port Branch  input  1  SHALL mark the held instruction as a conditional branch that is taken when eq=1.
REQ-016 Port JumpSel  input  1  SHALL mark the held instruction as an unconditional jump.
REQ-017 Port ImmOp  input  Data_Width  SHALL carry the sign-extended branch/jump offset of the held instruction.
REQ-018 Port halted  output  1  SHALL be a sticky flag set when a misaligned next PC is detected.

Function
REQ-019 The FSM SHALL have the states IDLE, FETCH, HOLD and HALT.
REQ-020 IDLE SHALL last exactly one cycle after reset deassertion and then move to FETCH.
REQ-021 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, held stable until the cycle in which imem_ack=1.
REQ-022 imem_ack SHALL be ignored in every state except FETCH.
REQ-023 On FETCH with imem_ack=1, the block SHALL register instr<=imem_rdata and instr_valid<=1, and SHALL move to HOLD.
REQ-024 imem_req SHALL deassert in the cycle after the ack; the block SHALL have at most one request outstanding.
REQ-025 In HOLD, instr, pc and newPC SHALL stay stable while instr_ready=0.
REQ-026 In HOLD with instr_ready=1, the redirect condition SHALL be JumpSel | (Branch & eq).
REQ-027 When the redirect condition is true, next_pc SHALL be pc+ImmOp; otherwise next_pc SHALL be pc+4.
REQ-028 next_pc SHALL be computed modulo 2^Data_Width, so 32'hFFFFFFFC+4 wraps to 0.
REQ-029 If next_pc[1:0]==0, the block SHALL register pc<=next_pc and instr_valid<=0, and SHALL move to FETCH.
REQ-030 If next_pc[1:0]!=0, the block SHALL set halted<=1 and instr_valid<=0, SHALL leave pc unchanged, and SHALL move to HALT.
REQ-031 HALT SHALL be left only by reset; imem_req SHALL be 0 in HALT.
REQ-032 newPC SHALL always equal pc+4, with wrap.
REQ-033 Branch, JumpSel, eq and ImmOp SHALL be sampled only in the HOLD cycle in which instr_ready=1.
REQ-034 Throughput SHALL be one instruction per (2 + memory latency) cycles minimum; a zero-wait memory (ack in the first FETCH cycle) gives ready-to-next-valid in 2 cycles.

Reset
REQ-035 While rst_n=0, the block SHALL hold state=IDLE, pc=RESET_PC, newPC=RESET_PC+4, instr=0, instr_valid=0, imem_req=0 and halted=0.
REQ-036 Reset asserted mid-request or mid-HOLD SHALL immediately abandon the request and the held instruction; an imem_ack arriving during or after the reset cycle SHALL not be captured until a new FETCH.

Verification
REQ-037 Bench scenario: reset release, ack in first FETCH cycle with rdata=32'h00500093 -> imem_addr=0, instr_valid=1 two cycles after reset release, instr=32'h00500093, pc=0, newPC=4.
REQ-038 Bench scenario: ack delayed 3 cycles -> imem_req=1 and imem_addr constant for 4 cycles, then a single capture.
REQ-039 Bench scenario: HOLD at pc=8, Branch=1, eq=1, ImmOp=-8, instr_ready=1 -> next fetch address 0; same stimulus with eq=0 -> next fetch address 12.
REQ-040 Bench scenario: instr_ready=0 for 5 cycles -> outputs stable and no imem_req; JumpSel=1, ImmOp=32'h10 at pc=4 -> next fetch address 32'h14.
REQ-041 Bench scenario: JumpSel=1, ImmOp=2 -> halted=1, imem_req stays 0 forever, and pc is unchanged.
REQ-042 Bench scenario: RESET_PC=32'hFFFFFFFC, sequential consume -> second fetch address 0; rst_n pulsed low during a pending request -> outputs return to reset values asynchronously.
